// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_THREADS EX/MEM stages.
// One transaction in flight at a time: grant in IDLE, issue, optional read wait, one-cycle completion.
module mem_port_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_THREADS-1:0]   req_valid,
    input  logic [NUM_THREADS*32-1:0] req_addr,
    input  logic [NUM_THREADS*32-1:0] req_wdata,
    input  logic [NUM_THREADS-1:0]   req_write,
    input  logic [NUM_THREADS*2-1:0] req_cmd,
    output logic [NUM_THREADS-1:0]   req_ready,
    output logic [NUM_THREADS-1:0]   stall,
    output logic                     resp_valid,
    output logic [TID_W-1:0]         resp_tid,
    output logic [31:0]              resp_data,
    output logic                     mem_valid,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_write,
    output logic [1:0]               mem_cmd,
    output logic [TID_W-1:0]         mem_tid,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t            state_q, state_d;
    logic [TID_W-1:0]  last_q, last_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d;
    logic [1:0]        mem_cmd_q, mem_cmd_d;
    logic [TID_W-1:0]  mem_tid_q, mem_tid_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       addr_arr  [NUM_THREADS];
    logic [31:0]       wdata_arr [NUM_THREADS];
    logic [1:0]        cmd_arr   [NUM_THREADS];
    logic [TID_W-1:0]  cand;
    logic [TID_W-1:0]  win_idx;
    logic              win_found;

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            addr_arr[i]  = req_addr[32*i +: 32];
            wdata_arr[i] = req_wdata[32*i +: 32];
            cmd_arr[i]   = req_cmd[2*i +: 2];
        end
    end

    // Search upward from the thread after the last winner, wrapping around.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            cand = TID_W'((int'(last_q) + k) % NUM_THREADS);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = mem_write_q;
        mem_cmd_d   = mem_cmd_q;
        mem_tid_d   = mem_tid_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = ISSUE;
                    last_d      = win_idx;
                    mem_tid_d   = win_idx;
                    mem_addr_d  = addr_arr[win_idx];
                    mem_wdata_d = wdata_arr[win_idx];
                    mem_write_d = req_write[win_idx];
                    mem_cmd_d   = cmd_arr[win_idx];
                    // Cleared here so a store completes with zero data.
                    rdata_d     = '0;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = mem_write_q ? DONE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= TID_W'(NUM_THREADS - 1);
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_cmd_q   <= '0;
            mem_tid_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_cmd_q   <= mem_cmd_d;
            mem_tid_q   <= mem_tid_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == DONE) begin
            req_ready[mem_tid_q] = 1'b1;
        end
    end

    assign stall      = req_valid & ~req_ready;
    assign resp_valid = (state_q == DONE);
    assign resp_tid   = resp_valid ? mem_tid_q : '0;
    assign resp_data  = resp_valid ? rdata_q : '0;
    assign mem_valid  = (state_q == ISSUE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_write  = mem_write_q;
    assign mem_cmd    = mem_cmd_q;
    assign mem_tid    = mem_tid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a transaction-level timing model.
module tb_mem_port_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_mvalid;
        logic [1:0]  e_mtid;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_mwrite;
        logic [3:0]  e_ready;
        logic [1:0]  e_rtid;
        logic [31:0] e_rdata;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N-1:0]      req_write;
    logic [N*2-1:0]    req_cmd;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      stall;
    logic              resp_valid;
    logic [1:0]        resp_tid;
    logic [31:0]       resp_data;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_write;
    logic [1:0]        mem_cmd;
    logic [1:0]        mem_tid;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic [N-1:0]      t_valid;
    logic [N-1:0]      t_write;
    logic [31:0]       t_addr  [N];
    logic [31:0]       t_wdata [N];
    logic [1:0]        t_cmd   [N];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_THREADS(N), .TID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_write(req_write), .req_cmd(req_cmd),
        .req_ready(req_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_tid(resp_tid), .resp_data(resp_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_cmd(mem_cmd), .mem_tid(mem_tid),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Per-thread payload arrays packed onto the flat request buses.
    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_cmd   = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32] = t_addr[i];
            req_wdata[32*i +: 32] = t_wdata[i];
            req_cmd[2*i +: 2]    = t_cmd[i];
        end
    end
    assign req_valid = t_valid;
    assign req_write = t_write;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        int t;
        for (int k = 1; k <= N; k++) begin
            t = (last + k) % N;
            if (v[t[1:0]]) return t;
        end
        return -1;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic clear_inputs();
        t_valid    = '0;
        t_write    = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < N; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
            t_cmd[i]   = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " mem_valid"},  32'(mem_valid),  32'd0);
        checkOutput({tag, " mem_addr"},   mem_addr,        32'd0);
        checkOutput({tag, " mem_wdata"},  mem_wdata,       32'd0);
        checkOutput({tag, " mem_write"},  32'(mem_write),  32'd0);
        checkOutput({tag, " mem_cmd"},    32'(mem_cmd),    32'd0);
        checkOutput({tag, " mem_tid"},    32'(mem_tid),    32'd0);
        checkOutput({tag, " req_ready"},  32'(req_ready),  32'd0);
        checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, " resp_tid"},   32'(resp_tid),   32'd0);
        checkOutput({tag, " resp_data"},  resp_data,       32'd0);
        checkOutput({tag, " stall"},      32'(stall),      32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < N; i++) begin
            t_valid[i] = v.valid[i];
            t_write[i] = v.write[i];
            t_addr[i]  = v.addr;
            t_wdata[i] = v.wdata;
            t_cmd[i]   = 2'b10;
        end
        mem_ready  = v.mready;
        mem_rvalid = v.rvalid;
        mem_rdata  = v.rdata;
    endtask

    task automatic run_table();
        vec_t vecs[$];
        string r;
        // Thread 2 store, immediate accept
        vecs.push_back('{4'b0100, 4'b0100, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,
                         1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b1, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b0100, 4'b0100, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0100, 2'd2, 32'h0});
        vecs.push_back('{4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});
        // Thread 1 load, data three cycles after acceptance
        vecs.push_back('{4'b0010, 4'b0000, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0,
                         1'b1, 2'd1, 32'h40, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b0010, 4'b0000, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b0010, 4'b0000, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b0010, 4'b0000, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b0010, 4'b0000, 32'h40, 32'h0, 1'b0, 1'b1, 32'h12345678,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0010, 2'd1, 32'h12345678});
        vecs.push_back('{4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});
        // Stray read data in IDLE and during a store issue must be ignored
        vecs.push_back('{4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b1000, 4'b1000, 32'h200, 32'hCAFE0001, 1'b0, 1'b1, 32'hAAAA5555,
                         1'b1, 2'd3, 32'h200, 32'hCAFE0001, 1'b1, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b1000, 4'b1000, 32'h200, 32'hCAFE0001, 1'b0, 1'b1, 32'hAAAA5555,
                         1'b1, 2'd3, 32'h200, 32'hCAFE0001, 1'b1, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b1000, 4'b1000, 32'h200, 32'hCAFE0001, 1'b1, 1'b1, 32'hAAAA5555,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b1000, 2'd3, 32'h0});
        vecs.push_back('{4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0BAD0BAD,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});
        vecs.push_back('{4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0});

        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n]);
            tick();
            r = $sformatf("vec%0d", n);
            checkOutput({r, " mem_valid"},  32'(mem_valid),  32'(vecs[n].e_mvalid));
            checkOutput({r, " req_ready"},  32'(req_ready),  32'(vecs[n].e_ready));
            checkOutput({r, " resp_valid"}, 32'(resp_valid), 32'(vecs[n].e_ready != 4'b0));
            checkOutput({r, " stall"},      32'(stall),      32'(vecs[n].valid & ~vecs[n].e_ready));
            if (vecs[n].e_mvalid) begin
                checkOutput({r, " mem_tid"},   32'(mem_tid),   32'(vecs[n].e_mtid));
                checkOutput({r, " mem_addr"},  mem_addr,       vecs[n].e_maddr);
                checkOutput({r, " mem_wdata"}, mem_wdata,      vecs[n].e_mwdata);
                checkOutput({r, " mem_write"}, 32'(mem_write), 32'(vecs[n].e_mwrite));
                checkOutput({r, " mem_cmd"},   32'(mem_cmd),   32'd2);
            end
            if (vecs[n].e_ready != 4'b0) begin
                checkOutput({r, " resp_tid"},  32'(resp_tid), 32'(vecs[n].e_rtid));
                checkOutput({r, " resp_data"}, resp_data,     vecs[n].e_rdata);
            end
        end
    endtask

    // All four threads store back-to-back; pointer starts at 3 so thread 0 leads.
    task automatic run_continuous();
        int g;
        logic [3:0] oh;
        t_valid    = 4'b1111;
        t_write    = 4'b1111;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            t_addr[i]  = 32'h1000 + 32'(i) * 4;
            t_wdata[i] = 32'hA000_0000 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            g  = k % N;
            oh = 4'(1 << g);
            tick();
            checkOutput($sformatf("rr%0d mem_valid", k), 32'(mem_valid), 32'd1);
            checkOutput($sformatf("rr%0d mem_tid", k),   32'(mem_tid),   32'(g));
            checkOutput($sformatf("rr%0d mem_addr", k),  mem_addr,       32'h1000 + 32'(g) * 4);
            checkOutput($sformatf("rr%0d stall_issue", k), 32'(stall),   32'hF);
            tick();
            checkOutput($sformatf("rr%0d req_ready", k), 32'(req_ready), 32'(oh));
            checkOutput($sformatf("rr%0d resp_tid", k),  32'(resp_tid),  32'(g));
            checkOutput($sformatf("rr%0d stall_done", k), 32'(stall),    32'(4'hF & ~oh));
            tick();
            checkOutput($sformatf("rr%0d idle_mem_valid", k), 32'(mem_valid),  32'd0);
            checkOutput($sformatf("rr%0d idle_resp", k),      32'(resp_valid), 32'd0);
        end
        t_valid = '0;
        tick();
    endtask

    // Thread 2 held off for five issue cycles while its address keeps changing.
    task automatic run_backpressure();
        t_valid    = 4'b0100;
        t_write    = 4'b0100;
        t_addr[2]  = 32'h0000_0AA0;
        t_wdata[2] = 32'h5555_AAAA;
        mem_ready  = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp%0d mem_valid", k), 32'(mem_valid), 32'd1);
            checkOutput($sformatf("bp%0d mem_addr", k),  mem_addr,       32'h0000_0AA0);
            checkOutput($sformatf("bp%0d stall", k),     32'(stall),     32'b0100);
            t_addr[2] = $urandom;
            tick();
        end
        checkOutput("bp mem_valid_hold", 32'(mem_valid), 32'd1);
        checkOutput("bp mem_addr_hold",  mem_addr,       32'h0000_0AA0);
        checkOutput("bp mem_wdata_hold", mem_wdata,      32'h5555_AAAA);
        mem_ready = 1'b1;
        tick();
        checkOutput("bp resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("bp req_ready",  32'(req_ready),  32'b0100);
        t_valid   = '0;
        mem_ready = 1'b0;
        tick();
    endtask

    // Reset while thread 1 waits for read data; late data must be dropped.
    task automatic run_reset_mid();
        t_valid   = 4'b0010;
        t_write   = 4'b0000;
        t_addr[1] = 32'h0000_0300;
        mem_ready = 1'b1;
        tick();
        checkOutput("rst mem_tid_pre", 32'(mem_tid), 32'd1);
        tick();
        checkOutput("rst waiting", 32'(mem_valid | resp_valid), 32'd0);
        rst_n = 1'b0;
        clear_inputs();
        tick();
        check_all_zero("rst_mid");
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBADD_A7A0;
        tick();
        checkOutput("rst late resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst late req_ready",  32'(req_ready),  32'd0);
        checkOutput("rst late mem_valid",  32'(mem_valid),  32'd0);
        mem_rvalid = 1'b0;
        t_valid    = 4'b1111;
        t_write    = 4'b1111;
        tick();
        checkOutput("rst first winner", 32'(mem_tid),   32'd0);
        checkOutput("rst first valid",  32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        tick();
        checkOutput("rst first resp_tid", 32'(resp_tid), 32'd0);
        t_valid = '0;
        tick();
    endtask

    task automatic new_request(input int i);
        t_valid[i] = 1'b1;
        t_write[i] = 1'($urandom_range(0, 1));
        t_addr[i]  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        t_wdata[i] = $urandom;
        t_cmd[i]   = 2'($urandom_range(0, 3));
    endtask

    // Timing model: a transaction is granted in a free cycle, accepted on the first
    // mem_ready after the grant, and completes one cycle after acceptance (store)
    // or one cycle after the first read data following acceptance (load).
    task automatic run_random(input int cycles);
        int          m_last = N - 1;
        logic        m_active = 1'b0;
        int          m_tid = 0;
        logic [31:0] m_addr = '0;
        logic [31:0] m_wdata = '0;
        logic        m_write = 1'b0;
        logic [1:0]  m_cmd = '0;
        int          m_accept = -1;
        int          m_data = -1;
        logic [31:0] m_rdata = '0;
        int          free_from = 0;
        int          comp;
        int          o;
        int          served;
        logic        exp_mv;
        logic        exp_done;
        logic [3:0]  exp_rr;

        for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) new_request(i);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;

        for (int c = 0; c < cycles; c++) begin
            if (m_active) begin
                if (m_accept < 0) begin
                    if (mem_ready) begin
                        m_accept = c;
                        if (m_write) mem_model[m_addr] = m_wdata;
                    end
                end else if (!m_write && m_data < 0 && mem_rvalid) begin
                    m_data  = c;
                    m_rdata = mem_rdata;
                end
            end else if (c >= free_from && t_valid != '0) begin
                m_tid    = rr_pick(m_last, t_valid);
                m_last   = m_tid;
                m_addr   = t_addr[m_tid];
                m_wdata  = t_wdata[m_tid];
                m_write  = t_write[m_tid];
                m_cmd    = t_cmd[m_tid];
                m_active = 1'b1;
                m_accept = -1;
                m_data   = -1;
            end

            tick();
            o = c + 1;

            exp_mv = m_active && (m_accept < 0);
            checkOutput("rnd mem_valid", 32'(mem_valid), 32'(exp_mv));
            if (exp_mv) begin
                checkOutput("rnd mem_tid",   32'(mem_tid),   32'(m_tid));
                checkOutput("rnd mem_addr",  mem_addr,       m_addr);
                checkOutput("rnd mem_wdata", mem_wdata,      m_wdata);
                checkOutput("rnd mem_write", 32'(mem_write), 32'(m_write));
                checkOutput("rnd mem_cmd",   32'(mem_cmd),   32'(m_cmd));
            end

            comp = -1;
            if (m_active && m_accept >= 0) comp = m_write ? m_accept + 1 : ((m_data >= 0) ? m_data + 1 : -1);
            exp_done = m_active && (comp == o);
            exp_rr   = exp_done ? 4'(1 << m_tid) : 4'b0000;
            checkOutput("rnd resp_valid", 32'(resp_valid), 32'(exp_done));
            checkOutput("rnd req_ready",  32'(req_ready),  32'(exp_rr));

            served = -1;
            if (exp_done) begin
                checkOutput("rnd resp_tid",  32'(resp_tid), 32'(m_tid));
                checkOutput("rnd resp_data", resp_data,     m_write ? 32'h0 : m_rdata);
                m_active  = 1'b0;
                free_from = o + 1;
                served    = m_tid;
                if ($urandom_range(0, 1) == 1) new_request(m_tid);
                else t_valid[m_tid] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (i != served && !t_valid[i] && $urandom_range(0, 3) == 0) new_request(i);
            end

            mem_ready = ($urandom_range(0, 9) < 6);
            if (m_active && !m_write && m_accept >= 0 && m_data < 0) begin
                mem_rvalid = ($urandom_range(0, 9) < 4);
                mem_rdata  = load_value(m_addr);
            end else begin
                mem_rvalid = ($urandom_range(0, 9) < 2);
                mem_rdata  = $urandom;
            end
            #1;
            checkOutput("rnd stall", 32'(stall), 32'(t_valid & ~exp_rr));
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        do_reset();
        run_table();
        run_continuous();
        run_backpressure();
        run_reset_mid();
        do_reset();
        run_random(2000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single data-memory port among `NUM_THREADS` hardware threads, each with its own EX/MEM pipeline register, for the near-memory threading core. Each thread presents its EX/MEM memory request: address from ALU output, store data from reg2, `mem_write`, and `cmd_type`. The arbiter grants one thread at a time in round-robin order and drives the memory handshake. It stalls every requesting thread that has not yet been served, and returns read data to the thread that issued the request.

## Interface
- `NUM_THREADS`, 4, number of requesting threads (2..8)
- `TID_W`, $clog2(NUM_THREADS), thread-id width
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  NUM_THREADS  thread i has a pending memory op
- `req_addr`  in  NUM_THREADS*32  per-thread address, slice i = [32*i+31:32*i]
- `req_wdata`  in  NUM_THREADS*32  per-thread store data
- `req_write`  in  NUM_THREADS  1 = store, 0 = load
- `req_cmd`  in  NUM_THREADS*2  per-thread cmd_type, passed through
- `req_ready`  out  NUM_THREADS  one-cycle completion pulse to thread i
- `stall`  out  NUM_THREADS  combinational, req_valid & ~req_ready
- `resp_valid`  out  1  completion strobe, coincident with req_ready
- `resp_tid`  out  TID_W  thread being completed
- `resp_data`  out  32  load data; 0 for stores
- `mem_valid`  out  1  request to memory
- `mem_addr` / `mem_wdata`  out  32 each  registered payload
- `mem_write`  out  1; `mem_cmd`  out  2; `mem_tid`  out  TID_W
- `mem_ready`  in  1  memory accepts the request while mem_valid=1
- `mem_rvalid`  in  1  load data valid
- `mem_rdata`  in  32  load data

## Operation
- FSM states are IDLE, ISSUE, WAIT_RD, DONE. Reset sets IDLE.
- On reset, every output except `stall` is 0. `stall` is 0 whenever `req_valid` is 0.
- The round-robin pointer `last` resets to NUM_THREADS-1, so thread 0 wins the first arbitration.
- IDLE, when any `req_valid` bit is set:
  - winner = first set bit searching from last+1 upward, wrapping modulo NUM_THREADS.
  - Register the winner's addr, wdata, write, cmd and tid into the mem_* outputs.
  - Set last = winner and go to ISSUE.
- IDLE with no request: stay in IDLE.
- ISSUE:
  - `mem_valid`=1 and the payload is held stable until `mem_ready`=1.
  - On `mem_ready`, a store goes to DONE and a load goes to WAIT_RD.
  - `mem_valid` drops on the cycle after acceptance.
- WAIT_RD:
  - Wait for `mem_rvalid`, then capture `mem_rdata` and go to DONE.
  - `mem_rvalid` is sampled only in this state and is ignored elsewhere, including during the ISSUE acceptance cycle.
- DONE:
  - For exactly one cycle, drive `req_ready[tid]`=1, `resp_valid`=1, `resp_tid`=tid, and `resp_data` = captured data (0 for a store).
  - Next state is IDLE.
- Threads hold `req_valid` and the payload stable until their `req_ready` pulse. The arbiter samples the payload only in IDLE.
- If a granted thread drops `req_valid` early, that is a protocol violation. The transaction still completes and `req_ready` still pulses.
- Only one transaction is outstanding at a time. There is no pipelining across threads.

## Timing
- Store with immediate accept: request seen in IDLE at cycle 0, ISSUE at cycle 1 with `mem_ready`=1, DONE at cycle 2, IDLE at cycle 3. Minimum is 3 cycles per transaction.
- Load: ISSUE at cycle 1 (accepted), WAIT_RD from cycle 2, `mem_rvalid` at cycle k, DONE at cycle k+1.
- Backpressure: every cycle ISSUE spends with `mem_ready`=0 adds one cycle of latency, with no change to the payload.
- New requests or payload changes during ISSUE, WAIT_RD or DONE do not affect the active transaction.
- When all threads request continuously, each thread is served at most once per NUM_THREADS grants.
- Reset mid-transaction:
  - The next cycle is IDLE with `mem_valid`, `req_ready` and `resp_valid` at 0 and the pointer reset.
  - An in-flight memory response arriving after reset is ignored.

## Test plan
- Reset, then only thread 2 requests a store to addr 0x100, data 0xDEADBEEF, with `mem_ready` tied 1. Required: `mem_valid` in cycle 1 carrying 0x100/0xDEADBEEF/tid 2, then `req_ready`=4'b0100 and `resp_data`=0 in cycle 2.
- Thread 1 loads 0x40, `mem_ready`=1, and `mem_rvalid` arrives 3 cycles after acceptance with 0x12345678. Required: DONE one cycle later with `resp_tid`=1 and `resp_data`=0x12345678; `stall[1]`=1 until then.
- All four threads request stores continuously. Required grant order 0,1,2,3,0, one grant every 3 cycles, and `stall` high on every waiting thread.
- Hold `mem_ready`=0 for 5 cycles in ISSUE while the winner's `req_addr` changes. Required: `mem_addr` stays at the value latched at grant, and DONE follows 1 cycle after `mem_ready` rises.
- Assert `rst_n`=0 during WAIT_RD, then pulse `mem_rvalid` after reset. Required: all outputs 0, no `resp_valid`, and thread 0 wins the next arbitration.
- Pulse `mem_rvalid`=1 during a store ISSUE and during IDLE. Required: no state change and no `resp_valid`.
